bin_morph_filter: RTL and testbench
===================================

Name: bin_morph_filter

Overview:
- Binary morphology stage between the HSV colour-threshold output (Binary_PreProcess) and the centroid/render consumers (Binary_PostProcess).
- Two cascaded 3x3 window stages, each with its own line buffers, remove speckle (erode) and fill holes (dilate) in the 1-bit mask.
- The block emits Binary_out together with its aligned pixel coordinates, so downstream accumulation stays spatially correct.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_W, 12, horizontal counter width
- V_W, 11, vertical counter width

Ports:
- PClk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- VtcHCnt  in  H_W  horizontal counter, free-running including blanking
- VtcVCnt  in  V_W  vertical counter, free-running including blanking
- Binary_in  in  1  threshold mask pixel for (VtcHCnt, VtcVCnt)
- mode  in  2  00 bypass, 01 erode, 10 dilate, 11 open (erode then dilate)
- Binary_out  out  1  filtered pixel
- Hcnt_out  out  H_W  column of Binary_out
- Vcnt_out  out  V_W  row of Binary_out
- Valid_out  out  1  Hcnt_out < H_ACTIVE and Vcnt_out < V_ACTIVE, and armed

Behaviour:
- Clock and reset: one clock, PClk. Reset rst_n is asynchronous and active-low.
- Reset values: Binary_out=0, Hcnt_out=0, Vcnt_out=0, Valid_out=0, mode_q=00, armed=0, all window registers 0. Line-buffer RAM is not reset; the boundary rule masks it.
- Armed flag: set on the first cycle with VtcHCnt==0 && VtcVCnt==0 after reset. While armed=0, Binary_out=0 and Valid_out=0. Reset mid-frame therefore suppresses output until the next frame start.
- Mode sampling: mode_q <= mode only on cycles with VtcHCnt==0 && VtcVCnt==0. Mode changes mid-frame take effect at the next frame, so no frame is torn.
- Stage op mapping:
  - Stage1 = erode when mode_q[0]=1, otherwise pass.
  - Stage2 = dilate when mode_q[1]=1, otherwise pass.
- Stage structure (identical for both stages; stage2 inputs are stage1 outputs):
  - Input pixel p = b_i when h_i<H_ACTIVE && v_i<V_ACTIVE, else 0.
  - Two line buffers of H_ACTIVE+1 bits, addressed by h_i, written when h_i<=H_ACTIVE.
  - LB1 holds row v_i-1; LB2 holds row v_i-2.
  - A 3-column shift window holds columns h_i, h_i-1 and h_i-2 of rows v_i, v_i-1 and v_i-2. Window centre = (h_i-1, v_i-1).
  - Boundary rule: any tap whose coordinate lies outside [0,H_ACTIVE-1]x[0,V_ACTIVE-1] reads 0. This covers stale LB rows at v_i<2 and the previous-line columns at h_i<2.
- Stage ops:
  - Erode = AND of all 9 taps. Border pixels are always 0.
  - Dilate = OR of all 9 taps.
  - Pass = centre tap.
- Stage outputs (registered):
  - h_o <= h_i-1 and v_o <= v_i-1, modulo 2^W; 0-1 wraps to all-ones, which counts as out of range.
  - b_o <= op result when (h_i-1)<H_ACTIVE && (v_i-1)<V_ACTIVE (unsigned compare), else 0.
- Latency:
  - Fixed 2 cycles in every mode.
  - Binary_out at cycle t belongs to pixel (Hcnt_out, Vcnt_out) = (VtcHCnt-2, VtcVCnt-2) of cycle t-2.
  - Blanking must provide at least 2 columns and 2 lines so that pad column H_ACTIVE / pad row V_ACTIVE, and the stage-2 pad, are processed.
- Width rule: counters wrap within H_W/V_W; no saturation.

Optional Feature:
- Macro: MORPH_STATS_EN.
- Defined:
  - Adds output Pixel_count [20:0].
  - An internal 21-bit accumulator counts cycles with Valid_out && Binary_out.
  - On the cycle where Hcnt_out==H_ACTIVE-1 && Vcnt_out==V_ACTIVE-1 (last valid pixel), Pixel_count <= accumulator + current bit, and the accumulator clears.
  - Pixel_count resets to 0.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Bypass: mode=00, single 1 at (100,50) -> Binary_out=1 exactly when Hcnt_out=100, Vcnt_out=50, 2 cycles later; every other valid pixel 0.
- Erode speckle: mode=01, isolated 2x2 block at (200..201, 80..81) -> zero ones in frame. Solid 5x5 block at (300..304, 100..104) -> ones at exactly the 3x3 interior (301..303, 101..103).
- Dilate and border: mode=10, single 1 at (0,0) -> ones at (0,0), (1,0), (0,1), (1,1) only. Single 1 at (639,479) -> 2x2 at (638..639, 478..479).
- Open and mode timing: mode switched 00->11 at mid-frame line 240 -> the rest of that frame remains bypass. Next frame: 5x5 block preserved exactly, isolated pixel removed.
- Reset: rst_n low for 3 cycles at line 200 -> outputs 0 immediately; Valid_out stays 0 until VtcHCnt=0/VtcVCnt=0 plus 2 cycles; no stale-buffer ones in the first armed frame.
- Stats (MORPH_STATS_EN): mode=00, 10x10 block -> Pixel_count=100 after the last valid pixel. An all-ones frame in mode 01 -> 638*478=304964.

Source files
------------

// File: rtl/bin_morph_filter.sv
// Binary 3x3 morphology: stage 1 erodes, stage 2 dilates, either may pass through; 2-cycle latency.
// Optional MORPH_STATS_EN adds Pixel_count, the number of valid ones in the last completed frame.

module bin_morph_stage #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_W      = 12,
    parameter int V_W      = 11
) (
    input  logic           PClk,
    input  logic           rst_n,
    input  logic [H_W-1:0] h_i,
    input  logic [V_W-1:0] v_i,
    input  logic           b_i,
    input  logic           erode_en,
    input  logic           dilate_en,
    output logic [H_W-1:0] h_o,
    output logic [V_W-1:0] v_o,
    output logic           b_o
);
    localparam int AW = $clog2(H_ACTIVE + 1);
    localparam logic [H_W-1:0] H_LIM = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_LIM = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] H_ONE = H_W'(1);
    localparam logic [H_W-1:0] H_TWO = H_W'(2);
    localparam logic [V_W-1:0] V_ONE = V_W'(1);
    localparam logic [V_W-1:0] V_TWO = V_W'(2);

    logic lb1 [0:H_ACTIVE];
    logic lb2 [0:H_ACTIVE];

    // Column vectors: bit r holds row v_i-r; win1/win2 are columns h_i-1/h_i-2.
    logic [2:0]      col0, win1, win2;
    logic [2:0]      row_ok, col_ok;
    logic [2:0][2:0] tap;
    logic [H_W-1:0]  h_m1, h_m2;
    logic [V_W-1:0]  v_m1, v_m2;
    logic [AW-1:0]   addr;
    logic            lb_we, p, centre_ok, op;

    assign h_m1 = h_i - H_ONE;
    assign h_m2 = h_i - H_TWO;
    assign v_m1 = v_i - V_ONE;
    assign v_m2 = v_i - V_TWO;

    assign lb_we = (h_i <= H_LIM);
    assign addr  = lb_we ? h_i[AW-1:0] : '0;
    assign p     = b_i & (h_i < H_LIM) & (v_i < V_LIM);
    assign col0  = {lb2[addr], lb1[addr], p};

    // Negative offsets wrap to large unsigned values, so one compare covers both edges.
    assign row_ok = {v_m2 < V_LIM, v_m1 < V_LIM, v_i < V_LIM};
    assign col_ok = {h_m2 < H_LIM, h_m1 < H_LIM, h_i < H_LIM};

    assign tap[0] = col0 & row_ok & {3{col_ok[0]}};
    assign tap[1] = win1 & row_ok & {3{col_ok[1]}};
    assign tap[2] = win2 & row_ok & {3{col_ok[2]}};

    assign centre_ok = (h_m1 < H_LIM) && (v_m1 < V_LIM);

    always_comb begin
        op = tap[1][1];
        if (erode_en)
            op = &tap;
        else if (dilate_en)
            op = |tap;
    end

    always_ff @(posedge PClk) begin
        if (lb_we) begin
            lb1[addr] <= p;
            lb2[addr] <= lb1[addr];
        end
    end

    always_ff @(posedge PClk or negedge rst_n) begin
        if (!rst_n) begin
            win1 <= '0;
            win2 <= '0;
            h_o  <= '0;
            v_o  <= '0;
            b_o  <= 1'b0;
        end else begin
            win1 <= col0;
            win2 <= win1;
            h_o  <= h_m1;
            v_o  <= v_m1;
            b_o  <= centre_ok & op;
        end
    end
endmodule

module bin_morph_filter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_W      = 12,
    parameter int V_W      = 11
) (
    input  logic           PClk,
    input  logic           rst_n,
    input  logic [H_W-1:0] VtcHCnt,
    input  logic [V_W-1:0] VtcVCnt,
    input  logic           Binary_in,
    input  logic [1:0]     mode,
    output logic           Binary_out,
    output logic [H_W-1:0] Hcnt_out,
    output logic [V_W-1:0] Vcnt_out,
`ifdef MORPH_STATS_EN
    output logic [20:0]    Pixel_count,
`endif
    output logic           Valid_out
);
    localparam int STAGES = 2;
    localparam logic [H_W-1:0] H_LIM = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_LIM = V_W'(V_ACTIVE);

    logic [STAGES:0][H_W-1:0] hs;
    logic [STAGES:0][V_W-1:0] vs;
    logic [STAGES:0]          bs;
    logic [STAGES-1:0]        erode_en, dilate_en;
    logic [1:0]               mode_q;
    logic                     armed, frame_start;

    assign frame_start = (VtcHCnt == '0) && (VtcVCnt == '0);

    // Mode and arming only change at frame start so a frame is never torn.
    always_ff @(posedge PClk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 2'b00;
            armed  <= 1'b0;
        end else if (frame_start) begin
            mode_q <= mode;
            armed  <= 1'b1;
        end
    end

    assign hs[0]     = VtcHCnt;
    assign vs[0]     = VtcVCnt;
    assign bs[0]     = Binary_in;
    assign erode_en  = {1'b0, mode_q[0]};
    assign dilate_en = {mode_q[1], 1'b0};

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            bin_morph_stage #(
                .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_W(H_W), .V_W(V_W)
            ) u_stage (
                .PClk     (PClk),
                .rst_n    (rst_n),
                .h_i      (hs[g]),
                .v_i      (vs[g]),
                .b_i      (bs[g]),
                .erode_en (erode_en[g]),
                .dilate_en(dilate_en[g]),
                .h_o      (hs[g+1]),
                .v_o      (vs[g+1]),
                .b_o      (bs[g+1])
            );
        end
    endgenerate

    assign Hcnt_out   = hs[STAGES];
    assign Vcnt_out   = vs[STAGES];
    assign Binary_out = bs[STAGES] & armed;
    assign Valid_out  = armed && (Hcnt_out < H_LIM) && (Vcnt_out < V_LIM);

`ifdef MORPH_STATS_EN
    logic [20:0] acc;
    logic        hit, last_px;

    assign hit     = Valid_out & Binary_out;
    assign last_px = (Hcnt_out == H_LIM - H_W'(1)) && (Vcnt_out == V_LIM - V_W'(1));

    always_ff @(posedge PClk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            Pixel_count <= '0;
        end else if (last_px) begin
            Pixel_count <= acc + 21'(hit);
            acc         <= '0;
        end else begin
            acc         <= acc + 21'(hit);
        end
    end
`endif
endmodule

// File: tb/tb_bin_morph_filter.sv
// Frame-level bench for bin_morph_filter on a reduced 32x24 raster with 4 blanking columns/lines.
module tb_bin_morph_filter;
    localparam int HA = 32, VA = 24, HT = 36, VT = 28, HW = 12, VW = 11;

    typedef bit img_t [VA][HA];

    logic          PClk = 1'b0;
    logic          rst_n = 1'b0;
    logic [HW-1:0] VtcHCnt;
    logic [VW-1:0] VtcVCnt;
    logic          Binary_in;
    logic [1:0]    mode;
    logic          Binary_out, Valid_out;
    logic [HW-1:0] Hcnt_out;
    logic [VW-1:0] Vcnt_out;
`ifdef MORPH_STATS_EN
    logic [20:0]   Pixel_count;
`endif

    bin_morph_filter #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_W(HW), .V_W(VW)) dut (
        .PClk      (PClk),
        .rst_n     (rst_n),
        .VtcHCnt   (VtcHCnt),
        .VtcVCnt   (VtcVCnt),
        .Binary_in (Binary_in),
        .mode      (mode),
        .Binary_out(Binary_out),
        .Hcnt_out  (Hcnt_out),
        .Vcnt_out  (Vcnt_out),
`ifdef MORPH_STATS_EN
        .Pixel_count(Pixel_count),
`endif
        .Valid_out (Valid_out)
    );

    always #5 PClk = ~PClk;

    int   total = 0, bad = 0;
    img_t img, expimg, got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: zero-padded 3x3 AND / OR over the input image.
    function automatic bit win3(input img_t s, input int y, input int x, input bit is_and);
        bit r, t;
        r = is_and;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                t = 1'b0;
                if (y + dy >= 0 && y + dy < VA && x + dx >= 0 && x + dx < HA)
                    t = s[y + dy][x + dx];
                r = is_and ? (r & t) : (r | t);
            end
        return r;
    endfunction

    function automatic void compute_exp(input logic [1:0] m);
        img_t e;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                e[y][x] = m[0] ? win3(img, y, x, 1'b1) : img[y][x];
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                expimg[y][x] = m[1] ? win3(e, y, x, 1'b0) : e[y][x];
    endfunction

    function automatic int count_got();
        int n = 0;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                n += int'(got[y][x]);
        return n;
    endfunction

    task automatic clear_img();
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                img[y][x] = 1'b0;
    endtask

    task automatic set_block(input int x0, input int y0, input int w, input int h);
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                img[y][x] = 1'b1;
    endtask

    // Per-cycle compare: outputs now belong to the coordinates applied two cycles ago.
    logic [HW-1:0] hist_h [2];
    logic [VW-1:0] hist_v [2];
    int            hn = 0;
    bit            arm_m = 1'b0;
    logic [HW-1:0] eh;
    logic [VW-1:0] ev;
    bit            e_ok, e_b;

    always @(negedge PClk) begin
        if (!rst_n) begin
            hn    = 0;
            arm_m = 1'b0;
            check("rst_hold_out", 32'({Valid_out, Binary_out}), 32'd0);
        end else begin
            if (hn >= 2) begin
                eh   = hist_h[1] - HW'(2);
                ev   = hist_v[1] - VW'(2);
                check("coord", 32'({Hcnt_out, Vcnt_out}), 32'({eh, ev}));
                e_ok = arm_m && (int'(eh) < HA) && (int'(ev) < VA);
                e_b  = 1'b0;
                if (e_ok) e_b = expimg[int'(ev)][int'(eh)];
                check("pixel", 32'({Valid_out, Binary_out}), 32'({e_ok, e_b}));
                if (Valid_out && int'(Hcnt_out) < HA && int'(Vcnt_out) < VA)
                    got[int'(Vcnt_out)][int'(Hcnt_out)] = Binary_out;
            end
            hist_h[1] = hist_h[0];
            hist_v[1] = hist_v[0];
            hist_h[0] = VtcHCnt;
            hist_v[0] = VtcVCnt;
            hn++;
            if (VtcHCnt == '0 && VtcVCnt == '0) begin
                arm_m = 1'b1;
                compute_exp(mode);
            end
        end
    end

    task automatic drive_frame(input logic [1:0] m, input int sw_line, input logic [1:0] m2,
                               input int rst_line);
        int rst_cnt = 0;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                got[y][x] = 1'b0;
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++) begin
                @(posedge PClk);
                #1;
                VtcHCnt   = HW'(h);
                VtcVCnt   = VW'(v);
                Binary_in = (h < HA && v < VA) ? img[v][h] : 1'($urandom_range(0, 1));
                if (v == 0 && h == 0) mode = m;
                if (v == sw_line && h == 0) mode = m2;
                if (v == rst_line && h == 0) begin
                    rst_n   = 1'b0;
                    rst_cnt = 3;
                    #1;
                    check("rst_async", 32'({Binary_out, Valid_out, Hcnt_out, Vcnt_out}), 32'd0);
                    for (int y = 0; y < VA; y++)
                        for (int x = 0; x < HA; x++)
                            got[y][x] = 1'b0;
                end else if (rst_cnt > 0) begin
                    rst_cnt--;
                    if (rst_cnt == 0) rst_n = 1'b1;
                end
            end
    endtask

    initial begin
        VtcHCnt   = HW'(HT - 1);
        VtcVCnt   = VW'(VT - 1);
        Binary_in = 1'b0;
        mode      = 2'b00;
        repeat (3) @(posedge PClk);
        #1;
        check("reset_state", 32'({Binary_out, Valid_out, Hcnt_out, Vcnt_out}), 32'd0);
`ifdef MORPH_STATS_EN
        check("reset_pixel_count", 32'(Pixel_count), 32'd0);
`endif
        rst_n = 1'b1;

        // Bypass: single pixel
        clear_img(); img[5][10] = 1'b1;
        drive_frame(2'b00, -1, 2'b00, -1);
        check("bypass_cnt", 32'(count_got()), 32'd1);
        check("bypass_px", 32'(got[5][10]), 32'd1);

        // Erode: isolated 2x2 vanishes, 5x5 shrinks to 3x3
        clear_img(); set_block(4, 8, 2, 2); set_block(20, 10, 5, 5);
        drive_frame(2'b01, -1, 2'b01, -1);
        check("erode_cnt", 32'(count_got()), 32'd9);
        check("erode_in", 32'(got[11][21]), 32'd1);
        check("erode_in2", 32'(got[13][23]), 32'd1);
        check("erode_edge", 32'(got[10][20]), 32'd0);

        // Dilate at both frame corners
        clear_img(); img[0][0] = 1'b1; img[VA-1][HA-1] = 1'b1;
        drive_frame(2'b10, -1, 2'b10, -1);
        check("dilate_cnt", 32'(count_got()), 32'd8);
        check("dilate_tl", 32'(got[1][1]), 32'd1);
        check("dilate_br", 32'(got[VA-2][HA-2]), 32'd1);

        // Mode switched mid-frame: this frame stays bypass
        clear_img(); set_block(20, 10, 5, 5); img[5][5] = 1'b1;
        drive_frame(2'b00, 12, 2'b11, -1);
        check("midswitch_cnt", 32'(count_got()), 32'd26);
        check("midswitch_iso", 32'(got[5][5]), 32'd1);

        // Open on the next frame
        drive_frame(2'b11, -1, 2'b11, -1);
        check("open_cnt", 32'(count_got()), 32'd25);
        check("open_iso", 32'(got[5][5]), 32'd0);
        check("open_corner", 32'(got[14][24]), 32'd1);

        // Reset mid-frame with ones in the line buffers
        clear_img(); set_block(0, 0, HA, VA);
        drive_frame(2'b00, -1, 2'b00, 12);
        check("post_rst_cnt", 32'(count_got()), 32'd0);

        // First armed frame after reset: empty input, dilate must not pick up stale rows
        clear_img();
        drive_frame(2'b10, -1, 2'b10, -1);
        check("stale_cnt", 32'(count_got()), 32'd0);

        // All-ones erode
        clear_img(); set_block(0, 0, HA, VA);
        drive_frame(2'b01, -1, 2'b01, -1);
        check("allones_cnt", 32'(count_got()), 32'((HA - 2) * (VA - 2)));
`ifdef MORPH_STATS_EN
        check("stats_allones", 32'(Pixel_count), 32'((HA - 2) * (VA - 2)));
`endif

        // 10x10 block bypass
        clear_img(); set_block(3, 4, 10, 10);
        drive_frame(2'b00, -1, 2'b00, -1);
        check("block_cnt", 32'(count_got()), 32'd100);
`ifdef MORPH_STATS_EN
        check("stats_block", 32'(Pixel_count), 32'd100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
